alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_fifo.sv | 76 +++++++
 rtl/alu_op_issuer.sv | 131 +++++++++++++
 tb/tb_alu_op_issuer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU select codes, operand/result widths and issuer states.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W  = 2;
    localparam int RES_W = 3;
    localparam int OPR_W = 3 * OP_W;

    localparam logic [OP_W-1:0] SEL_ADD = 2'b00;
    localparam logic [OP_W-1:0] SEL_SUB = 2'b01;
    localparam logic [OP_W-1:0] SEL_AND = 2'b10;
    localparam logic [OP_W-1:0] SEL_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [OP_W-1:0] sel;
    } op_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_fifo.sv
`default_nettype none
// ============================================================================
// Module : alu_op_fifo
// Brief  : Power-of-two circular FIFO holding queued ALU operations.
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : alu_op_fifo
`default_nettype wire

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_issuer
// Brief  : Queues ALU operations, issues them to an external 2-bit ALU and
//          presents each captured result with a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    input  logic [OP_W-1:0]         in_sel,
    output logic [OP_W-1:0]         alu_a,
    output logic [OP_W-1:0]         alu_b,
    output logic [OP_W-1:0]         alu_sel,
    input  logic [RES_W-1:0]        alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OP_W-1:0]         out_a,
    output logic [OP_W-1:0]         out_b,
    output logic [OP_W-1:0]         out_sel,
    output logic [RES_W-1:0]        out_result,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    state_t           state_q,      state_d;
    op_t              op_q,         op_d;
    op_t              out_op_q,     out_op_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic             out_valid_q,  out_valid_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    op_t              fifo_head;
    op_t              in_op;

    assign in_op     = '{a: in_a, b: in_b, sel: in_sel};
    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (OPR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_op),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        out_op_d     = out_op_q;
        out_result_d = out_result_q;
        out_valid_d  = out_valid_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                out_op_d     = op_q;
                out_result_d = alu_result;
                out_valid_d  = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                // Retiring a result and issuing the next queued op share one edge.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        op_d     = fifo_head;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            out_op_q     <= '0;
            out_result_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            out_op_q     <= out_op_d;
            out_result_q <= out_result_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign alu_a      = op_q.a;
    assign alu_b      = op_q.b;
    assign alu_sel    = op_q.sel;
    assign out_a      = out_op_q.a;
    assign out_b      = out_op_q.b;
    assign out_sel    = out_op_q.sel;
    assign out_result = out_result_q;
    assign out_valid  = out_valid_q;

endmodule : alu_op_issuer
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_issuer
// Brief  : Scoreboard bench for alu_op_issuer with a behavioural 2-bit ALU.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_op_issuer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a, in_b, in_sel;
    logic [1:0] alu_a, alu_b, alu_sel;
    logic [2:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_a, out_b, out_sel;
    logic [2:0] out_result;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    alu_op_issuer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_sel    (out_sel),
        .out_result (out_result),
        .fifo_count (fifo_count)
    );

    // External ALU_2bit stand-in; subtraction wraps in 3 bits.
    always_comb begin
        case (alu_sel)
            2'b00:   alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   alu_result = {1'b0, alu_a & alu_b};
            default: alu_result = {1'b0, alu_a | alu_b};
        endcase
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_xfer = 0;
    bit have_last = 1'b0;
    bit gap_chk   = 1'b0;

    // Entry layout: {a[1:0], b[1:0], sel[1:0], expected result[2:0]}
    logic [8:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_out actual=%b required=no result", {out_a, out_b, out_sel, out_result});
            end else begin
                if ({out_a, out_b, out_sel, out_result} !== sb[0]) begin
                    errors++;
                    $display("FAIL out_data actual=%b required=%b", {out_a, out_b, out_sel, out_result}, sb[0]);
                end
                if (out_ready) begin
                    if (gap_chk && have_last) begin
                        checks++;
                        if (cyc - last_xfer != 2) begin
                            errors++;
                            $display("FAIL throughput_gap actual=%0d required=2", cyc - last_xfer);
                        end
                    end
                    last_xfer = cyc;
                    have_last = 1'b1;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Offers one op for one cycle; called and returns at posedge+1.
    task automatic offer(input logic [8:0] v, output bit acc);
        in_a     = v[8:7];
        in_b     = v[6:5];
        in_sel   = v[4:3];
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc) sb.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    logic [8:0] burst_v [4] = '{9'b11_01_01_010, 9'b10_01_10_000, 9'b10_01_11_011, 9'b01_10_00_011};
    logic [8:0] full_v  [6] = '{9'b00_00_00_000, 9'b11_11_00_110, 9'b11_10_01_001,
                                9'b01_11_01_110, 9'b11_01_10_001, 9'b10_11_11_011};
    logic [8:0] sim_v   [4] = '{9'b01_01_00_010, 9'b10_10_00_100, 9'b11_00_11_011, 9'b01_00_01_001};
    logic [8:0] rst_v   [6] = '{9'b11_11_00_110, 9'b10_01_01_001, 9'b11_10_10_010,
                                9'b01_10_11_011, 9'b00_11_01_101, 9'b10_10_01_000};

    initial begin
        bit acc;
        int n_acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sel    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
        chk("rst_out", int'({out_a, out_b, out_sel, out_result}), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single op and latency
        offer(9'b01_10_00_011, acc);
        chk("single_acc", int'(acc), 1);
        chk("lat_e0", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_e1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_e2", int'(out_valid), 1);
        drain("single_drain", 20);

        // Back-to-back burst, one result per two cycles
        gap_chk   = 1'b1;
        have_last = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 4; i++) begin
            offer(burst_v[i], acc);
            n_acc += int'(acc);
        end
        chk("burst_acc", n_acc, 4);
        drain("burst_drain", 30);
        gap_chk = 1'b0;

        // Fill under backpressure: one op sits in DONE, DEPTH queued, last refused
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            offer(full_v[i], acc);
            n_acc += int'(acc);
        end
        chk("full_last_refused", int'(acc), 0);
        chk("full_acc", n_acc, DEPTH + 1);
        chk("full_count", int'(fifo_count), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        drain("full_drain", 60);

        // Held result stays stable for 5 stalled cycles, then a single transfer
        out_ready = 1'b0;
        offer(9'b10_11_01_111, acc);
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_valid", int'(out_valid), 1);
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_held", int'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_single_xfer", int'(out_valid), 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Simultaneous push and pop at count 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer(sim_v[i], acc);
        chk("sim_pre_count", int'(fifo_count), 2);
        out_ready = 1'b1;
        offer(sim_v[3], acc);
        chk("sim_acc", int'(acc), 1);
        chk("sim_post_count", int'(fifo_count), 2);
        drain("sim_drain", 30);

        // Asynchronous reset while in EXEC with three ops queued
        for (int i = 0; i < 6; i++) offer(rst_v[i], acc);
        chk("pre_rst_count", int'(fifo_count), 3);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_alu", int'({alu_a, alu_b, alu_sel}), 0);
        chk("arst_out", int'({out_a, out_b, out_sel, out_result}), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("in_ready_after_arst", int'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_valid", int'(out_valid), 0);
        chk("no_stale_count", int'(fifo_count), 0);
        offer(9'b01_10_11_011, acc);
        chk("post_rst_acc", int'(acc), 1);
        drain("post_rst_drain", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_op_issuer
`default_nettype wire
